// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain stage for the async FIFO.
// Converts the FIFO's rd_en/empty/registered-data interface (1-cycle read
// latency) into a valid/ready stream, prefetching into a small circular
// buffer so the consumer can take one beat per clock.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16,
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d;

    logic                  push, pop;
    logic [OCC_W:0]        reserved;

    // Returning read data is dropped if a flush lands in its capture cycle.
    assign push = inflight_q & ~flush;
    assign pop  = (occ_q != '0) & out_ready;

    // Slots already held plus the one promised to an outstanding read; using
    // only registered state keeps rd_en free of any path from out_ready.
    assign reserved   = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    assign fifo_rd_en = reset_n & ~flush & ~fifo_empty & (reserved < DEPTH_C);

    assign out_valid  = (occ_q != '0);
    assign out_data   = mem_q[head_q];
    assign occupancy  = occ_q;
    assign beat_count = beat_q;

    // Next-state for pointers, occupancy and beat counter; pointers wrap at
    // BUF_DEPTH so non-power-of-2 depths work.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        beat_d = beat_q;
        if (pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
            beat_d = beat_q + CNT_WIDTH'(1);
        end
        if (push) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        // A handshake in the flush cycle still counts; everything held is dropped.
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    // State registers and buffer writes, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            beat_q     <= beat_d;
            if (push) mem_q[tail_q] <= fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: a depth-3 instance for the main
// scenarios and a depth-2 / 4-bit-counter instance for reduced throughput and
// beat counter wrap. Each side is fed by a small behavioural FIFO with a
// 1-cycle registered read.
module tb_fifo_rd_stream_adapter;

    logic       clk = 1'b0;
    logic       reset_n;
    int         n_chk = 0;
    int         n_fail = 0;

    // depth-3 instance
    logic       fifo_empty, fifo_rd_en, flush, out_valid, out_ready;
    logic [7:0] fifo_rd_data, out_data;
    logic [1:0] occupancy;
    logic [15:0] beat_count;

    // depth-2 instance, 4-bit counter
    logic       fifo_empty2, fifo_rd_en2, out_valid2, out_ready2;
    logic [7:0] fifo_rd_data2, out_data2;
    logic [1:0] occupancy2;
    logic [3:0] beat_count2;

    // behavioural FIFOs
    logic [7:0] fmem  [256];
    logic [7:0] fmem2 [256];
    logic [7:0] wr_ptr = 8'd0, rd_ptr = 8'd0;
    logic [7:0] wr_ptr2 = 8'd0, rd_ptr2 = 8'd0;

    always #5 clk = ~clk;

    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_empty2 = (rd_ptr2 == wr_ptr2);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
        if (fifo_rd_en2) begin
            fifo_rd_data2 <= fmem2[rd_ptr2];
            rd_ptr2       <= rd_ptr2 + 8'd1;
        end
    end

    fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .beat_count(beat_count)
    );

    fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(2), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty2),
        .fifo_rd_data(fifo_rd_data2), .fifo_rd_en(fifo_rd_en2), .flush(1'b0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .occupancy(occupancy2), .beat_count(beat_count2)
    );

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic push2(input logic [7:0] d);
        fmem2[wr_ptr2] = d;
        wr_ptr2 = wr_ptr2 + 8'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd0 ||
                beat_count !== 16'd0 || out_data !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: rd_en=%b valid=%b occ=%0d cnt=%0d data=%h, want 0 0 0 0 00",
                         i, fifo_rd_en, out_valid, occupancy, beat_count, out_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push(8'hA5);
        #1;
        n_chk++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++; $display("FAIL single_issue: rd_en=%b want 1", fifo_rd_en);
        end
        @(negedge clk);
        n_chk++;
        if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_t1: rd_en=%b valid=%b want 0 0", fifo_rd_en, out_valid);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_t2: valid=%b data=%h want 1 a5", out_valid, out_data);
        end
        @(negedge clk);
        n_chk++;
        if (beat_count !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_t3: cnt=%0d valid=%b want 1 0", beat_count, out_valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 32; i++) push(8'(i));
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL stream beat %0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, 8'(i + 1));
            end
            @(negedge clk);
        end
        n_chk++;
        if (out_valid !== 1'b0 || beat_count !== 16'd32) begin
            n_fail++; $display("FAIL stream_end: valid=%b cnt=%0d want 0 32", out_valid, beat_count);
        end
    endtask

    task automatic test_backpressure();
        int exp_v;
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (6) @(negedge clk);
        n_chk++;
        if (occupancy !== 2'd3 || fifo_rd_en !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01) begin
            n_fail++;
            $display("FAIL bp_hold: occ=%0d rd_en=%b valid=%b data=%h want 3 0 1 01",
                     occupancy, fifo_rd_en, out_valid, out_data);
        end
        @(negedge clk);
        n_chk++;
        if (out_data !== 8'h01) begin
            n_fail++; $display("FAIL bp_stable: data=%h want 01", out_data);
        end
        out_ready = 1'b1;
        exp_v = 1;
        for (int c = 0; c < 40 && exp_v <= 8; c++) begin
            if (out_valid) begin
                n_chk++;
                if (out_data !== 8'(exp_v)) begin
                    n_fail++; $display("FAIL bp_drain: data=%h want %h", out_data, 8'(exp_v));
                end
                exp_v++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (exp_v != 9 || beat_count !== 16'd8 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: next=%0d cnt=%0d valid=%b want 9 8 0", exp_v, beat_count, out_valid);
        end
    endtask

    task automatic test_flush();
        int exp_v;
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'h30 + 8'(i));
        repeat (3) @(negedge clk);
        n_chk++;
        if (occupancy !== 2'd2) begin
            n_fail++; $display("FAIL flush_pre: occ=%0d want 2", occupancy);
        end
        flush = 1'b1;
        #1;
        n_chk++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL flush_rd_en: rd_en=%b want 0", fifo_rd_en);
        end
        @(negedge clk);
        flush = 1'b0;
        n_chk++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_after: occ=%0d valid=%b want 0 0", occupancy, out_valid);
        end
        out_ready = 1'b1;
        exp_v = 8'h34;
        for (int c = 0; c < 20 && exp_v <= 8'h35; c++) begin
            if (out_valid) begin
                n_chk++;
                if (out_data !== 8'(exp_v)) begin
                    n_fail++; $display("FAIL flush_drain: data=%h want %h", out_data, 8'(exp_v));
                end
                exp_v++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (exp_v != 8'h36 || beat_count !== 16'd2) begin
            n_fail++; $display("FAIL flush_end: next=%h cnt=%0d want 36 2", exp_v, beat_count);
        end
    endtask

    task automatic test_reset_mid();
        int exp_v;
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(8'h40 + 8'(i));
        repeat (4) @(negedge clk);
        n_chk++;
        if (occupancy !== 2'd3) begin
            n_fail++; $display("FAIL rmid_pre: occ=%0d want 3", occupancy);
        end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL rmid_rd_en: rd_en=%b want 0", fifo_rd_en);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n_chk++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'd0 || beat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_after: valid=%b occ=%0d data=%h cnt=%0d want 0 0 00 0",
                     out_valid, occupancy, out_data, beat_count);
        end
        out_ready = 1'b1;
        exp_v = 8'h44;
        for (int c = 0; c < 20 && exp_v <= 8'h46; c++) begin
            if (out_valid) begin
                n_chk++;
                if (out_data !== 8'(exp_v)) begin
                    n_fail++; $display("FAIL rmid_drain: data=%h want %h", out_data, 8'(exp_v));
                end
                exp_v++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (exp_v != 8'h47 || beat_count !== 16'd3) begin
            n_fail++; $display("FAIL rmid_end: next=%h cnt=%0d want 47 3", exp_v, beat_count);
        end
    endtask

    task automatic test_depth2_wrap();
        int k;
        int cyc;
        do_reset();
        out_ready2 = 1'b1;
        for (int i = 0; i < 32; i++) push2(8'h80 + 8'(i));
        k = 0;
        cyc = 0;
        while (cyc < 100 && k < 32) begin
            if (out_valid2) begin
                n_chk++;
                if (out_data2 !== 8'h80 + 8'(k) || beat_count2 !== 4'(k)) begin
                    n_fail++;
                    $display("FAIL d2_beat %0d: data=%h cnt=%0d want %h %0d",
                             k, out_data2, beat_count2, 8'h80 + 8'(k), 4'(k));
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (k != 32 || beat_count2 !== 4'd0) begin
            n_fail++; $display("FAIL d2_end: beats=%0d cnt=%0d want 32 0", k, beat_count2);
        end
        n_chk++;
        if (cyc <= 40) begin
            n_fail++; $display("FAIL d2_rate: cycles=%0d want more than 40", cyc);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_depth2_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
